// File: rtl/multiplier_shift_add_if.sv
// Start/ready/done bus for the shift-add multiplier.
// Carries operands, dividend reference, handshake and result/match outputs.
interface multiplier_shift_add_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   quotient_in;
    logic [WIDTH-1:0]   divisor_in;
    logic [WIDTH-1:0]   remainder_in;
    logic [2*WIDTH-1:0] dividend_ref;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               match;

    modport master (
        output start, quotient_in, divisor_in, remainder_in, dividend_ref,
        input  ready, done, product, match
    );

    modport slave (
        input  start, quotient_in, divisor_in, remainder_in, dividend_ref,
        output ready, done, product, match
    );
endinterface

// File: rtl/multiplier_shift_add.sv
// Sequential shift-add multiplier: product = A*B + R, one partial product per clock.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/operands in, ready/done/product/match out).
module multiplier_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multiplier_shift_add_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] ref_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    logic               match;

    logic               last;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    assign last     = (count == CW'(WIDTH - 1));
    // Partial product for the multiplier bit scanned this cycle.
    assign addend   = b_reg[count] ? ({{WIDTH{1'b0}}, a_reg} << count) : '0;
    // A*B + R <= 2^(2W) - 2^W, so a 2W-bit sum never overflows.
    assign acc_next = acc + addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = BUSY;
            BUSY:    if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            ref_reg <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            match   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.quotient_in;
                        b_reg   <= bus.divisor_in;
                        ref_reg <= bus.dividend_ref;
                        acc     <= {{WIDTH{1'b0}}, bus.remainder_in};
                        count   <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    // Counter holds on the last iteration; only acceptance reloads it.
                    if (last) begin
                        product <= acc_next;
                        match   <= (acc_next == ref_reg);
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product;
    assign bus.match   = match;
endmodule

// File: tb/tb_multiplier_shift_add.sv
// Directed self-checking bench for multiplier_shift_add.
// Drives on negedge, samples on negedge; every check goes through chk.
module tb_multiplier_shift_add;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    multiplier_shift_add_if #(.WIDTH(W)) bus ();

    multiplier_shift_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic [15:0] rf);
        bus.quotient_in  = a;
        bus.divisor_in   = b;
        bus.remainder_in = r;
        bus.dividend_ref = rf;
    endtask

    // Wait (from a negedge inside cycle 0 after acceptance) for done.
    // Returns the edge offset from E0 at which done is sampled high.
    task automatic wait_done(output int lat);
        int k;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
        lat = k + 1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic [15:0] rf,
                          input logic [15:0] exp_p, input logic exp_m);
        int lat;
        @(negedge clk);
        set_ops(a, b, r, rf);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        set_ops(8'hAA, 8'h55, 8'h33, 16'h0);
        chk({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_product"}, 32'(bus.product), 32'(exp_p));
        chk({tag, "_match"}, 32'(bus.match), 32'(exp_m));
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
        chk({tag, "_prod_hold"}, 32'(bus.product), 32'(exp_p));
    endtask

    initial begin
        int k;
        int lat;
        int extra;
        int nd;
        int c_first;
        int c_prev;
        logic held;
        logic [7:0]  oa [3];
        logic [7:0]  ob [3];
        logic [7:0]  orr [3];
        logic [15:0] op [3];

        bus.start = 1'b0;
        set_ops(8'd0, 8'd0, 8'd0, 16'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_match", 32'(bus.match), 32'd0);
        rst_n = 1'b1;

        // Basic and corner vectors
        run_op("basic", 8'd13, 8'd17, 8'd5, 16'd226, 16'd226, 1'b1);
        run_op("max", 8'd255, 8'd255, 8'd255, 16'hFF01, 16'hFF00, 1'b0);
        run_op("zero_a", 8'd0, 8'd200, 8'd7, 16'd7, 16'd7, 1'b1);
        run_op("ident", 8'd200, 8'd1, 8'd0, 16'd0, 16'd200, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        set_ops(8'd3, 8'd4, 8'd0, 16'd12);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        set_ops(8'd9, 8'd9, 8'd0, 16'd81);
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
            bus.start = (k == 3);
        end
        bus.start = 1'b0;
        chk("busy_latency", 32'(k + 1), 32'd9);
        chk("busy_product", 32'(bus.product), 32'd12);
        chk("busy_match", 32'(bus.match), 32'd1);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk("busy_no_second_done", 32'(extra), 32'd0);
        chk("busy_ready_after", 32'(bus.ready), 32'd1);

        // Reset mid-operation
        set_ops(8'd50, 8'd50, 8'd1, 16'd2501);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_product", 32'(bus.product), 32'd0);
        chk("midrst_match", 32'(bus.match), 32'd0);
        rst_n = 1'b1;
        run_op("after_rst", 8'd50, 8'd50, 8'd1, 16'd2501, 16'd2501, 1'b1);

        // Back-to-back with start held high
        oa[0] = 8'd2;   ob[0] = 8'd3;  orr[0] = 8'd1;   op[0] = 16'd7;
        oa[1] = 8'd10;  ob[1] = 8'd10; orr[1] = 8'd0;   op[1] = 16'd100;
        oa[2] = 8'd255; ob[2] = 8'd1;  orr[2] = 8'd255; op[2] = 16'd510;
        @(negedge clk);
        set_ops(oa[0], ob[0], orr[0], op[0]);
        bus.start = 1'b1;
        nd = 0;
        c_first = 0;
        c_prev = 0;
        held = 1'b1;
        k = 0;
        while (nd < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                chk($sformatf("b2b_product%0d", nd), 32'(bus.product), 32'(op[nd]));
                if (nd == 0) c_first = k;
                else chk($sformatf("b2b_gap%0d", nd), 32'(k - c_prev), 32'd10);
                c_prev = k;
                nd++;
                if (nd < 3) set_ops(oa[nd], ob[nd], orr[nd], op[nd]);
            end else if (nd > 0 && bus.product !== op[nd-1]) begin
                held = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", 32'(nd), 32'd3);
        chk("b2b_first_latency", 32'(c_first), 32'd9);
        chk("b2b_hold", 32'(held), 32'd1);

        lat = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
